// File: rtl/alu_exec_if.sv
// ID/EX-to-execute and execute-to-MEM handshake bundle for alu_exec_stage.
// master: the producer/consumer side (pipeline or bench); slave: the ALU stage.
interface alu_exec_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_cntl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [4:0]       tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cond;
    logic             illegal;
    logic [4:0]       out_tag;

    modport master (
        output in_valid, alu_cntl, op_a, op_b, tag, flush, out_ready,
        input  in_ready, out_valid, result, cond, illegal, out_tag
    );

    modport slave (
        input  in_valid, alu_cntl, op_a, op_b, tag, flush, out_ready,
        output in_ready, out_valid, result, cond, illegal, out_tag
    );
endinterface

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU with a single-entry registered output stage and saturating debug counters.
// Optional signed-overflow flag output ovf_o is enabled by defining ALU_OVF_TRAP_EN.
module alu_exec_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_exec_if.slave        bus,
    output logic [CNT_W-1:0] op_count_o,
    output logic [CNT_W-1:0] ill_count_o
`ifdef ALU_OVF_TRAP_EN
    ,
    output logic             ovf_o
`endif
);

    typedef enum logic {StEmpty, StFull} state_e;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q;
    logic [WIDTH-1:0] result_q;
    logic             cond_q;
    logic             illegal_q;
    logic [4:0]       tag_q;
    logic [CNT_W-1:0] op_count_q;
    logic [CNT_W-1:0] ill_count_q;

    logic             out_valid;
    logic             accept;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             lt_s;
    logic             lt_u;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cond;
    logic             alu_ill;

    assign out_valid = (state_q == StFull);
    assign bus.in_ready = !out_valid || bus.out_ready;
    assign accept = bus.in_valid && bus.in_ready && !bus.flush;

    assign sum  = bus.op_a + bus.op_b;
    assign diff = bus.op_a - bus.op_b;
    assign lt_s = $signed(bus.op_a) < $signed(bus.op_b);
    assign lt_u = bus.op_a < bus.op_b;

    always_comb begin
        alu_res  = '0;
        alu_ill  = 1'b0;
        alu_cond = 1'b0;
        case (bus.alu_cntl)
            4'b0000: alu_res = bus.op_a & bus.op_b;
            4'b0001: alu_res = bus.op_a | bus.op_b;
            4'b0010: alu_res = sum;
            4'b0011: alu_res = bus.op_a ^ bus.op_b;
            4'b0110: alu_res = diff;
            4'b0111: alu_res = diff;
            4'b1100: alu_res = ~(bus.op_a | bus.op_b);
            4'b1101: alu_res = {{(WIDTH-1){1'b0}}, lt_s};
            4'b1110: alu_res = {{(WIDTH-1){1'b0}}, lt_u};
            default: alu_ill = 1'b1;
        endcase
        // bne inverts the zero test; illegal codes never raise cond
        if (!alu_ill) begin
            alu_cond = (bus.alu_cntl == 4'b0111) ? (|alu_res) : ~(|alu_res);
        end
    end

`ifdef ALU_OVF_TRAP_EN
    logic ovf_q;
    logic alu_ovf;

    always_comb begin
        alu_ovf = 1'b0;
        if (bus.alu_cntl == 4'b0010) begin
            alu_ovf = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) &&
                      (sum[WIDTH-1] != bus.op_a[WIDTH-1]);
        end else if (bus.alu_cntl == 4'b0110 || bus.alu_cntl == 4'b0111) begin
            alu_ovf = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) &&
                      (diff[WIDTH-1] != bus.op_a[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= alu_ovf;
        end
    end

    assign ovf_o = ovf_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StEmpty;
            result_q    <= '0;
            cond_q      <= 1'b0;
            illegal_q   <= 1'b0;
            tag_q       <= '0;
            op_count_q  <= '0;
            ill_count_q <= '0;
        end else if (bus.flush) begin
            state_q <= StEmpty;
        end else if (accept) begin
            state_q   <= StFull;
            result_q  <= alu_res;
            cond_q    <= alu_cond;
            illegal_q <= alu_ill;
            tag_q     <= bus.tag;
            if (op_count_q != '1) begin
                op_count_q <= op_count_q + CntOne;
            end
            if (alu_ill && (ill_count_q != '1)) begin
                ill_count_q <= ill_count_q + CntOne;
            end
        end else if (out_valid && bus.out_ready) begin
            state_q <= StEmpty;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.result    = result_q;
    assign bus.cond      = cond_q;
    assign bus.illegal   = illegal_q;
    assign bus.out_tag   = tag_q;
    assign op_count_o    = op_count_q;
    assign ill_count_o   = ill_count_q;

endmodule
